// File: rtl/abd_mem_pkg.sv
// Shared types for the abd dual-port RAM: collision policy and init-sequencer states.
package abd_mem_pkg;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } write_mode_e;

    typedef enum logic {
        INIT_CLEAR = 1'b0,
        READY      = 1'b1
    } init_state_e;

endpackage

// File: rtl/abd_rd_pipe.sv
// Read output stage: carries valid/data for 1 or 2 cycles; data holds its last valid value.
module abd_rd_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    always_ff @(posedge clock) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) s1_data <= in_data;
        end
    end

    // Outputs are forced low combinationally so they read zero in every cycle rst is high.
    generate
        if (READ_LATENCY == 2) begin : g_two
            logic                  s2_valid;
            logic [DATA_WIDTH-1:0] s2_data;

            always_ff @(posedge clock) begin
                if (rst) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) s2_data <= s1_data;
                end
            end

            assign out_valid = s2_valid & ~rst;
            assign out_data  = rst ? '0 : s2_data;
        end else begin : g_one
            assign out_valid = s1_valid & ~rst;
            assign out_data  = rst ? '0 : s1_data;
        end
    endgenerate

endmodule

// File: rtl/abd_dpram.sv
// Dual-port RAM: port A read/write with byte enables, port B read-only, optional clear after reset.
//   state      | meaning
//   INIT_CLEAR | sweeping zeros into the array one word per cycle; requests ignored
//   READY      | normal operation; left only through rst
module abd_dpram
    import abd_mem_pkg::*;
#(
    parameter int          DATA_WIDTH     = 32,
    parameter int          DEPTH          = 1024,
    parameter int          READ_LATENCY   = 1,
    parameter write_mode_e WRITE_MODE     = READ_FIRST,
    parameter int          CLEAR_ON_RESET = 1,
    localparam int         ADDR_WIDTH     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clock,
    input  logic                    rst,
    output logic                    init_busy,
    input  logic                    a_req,
    input  logic                    a_we,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_wdata,
    output logic [DATA_WIDTH-1:0]   a_rdata,
    output logic                    a_rvalid,
    input  logic                    b_req,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    output logic [DATA_WIDTH-1:0]   b_rdata,
    output logic                    b_rvalid
);

    localparam int                    NUM_BYTES   = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
    localparam init_state_e           RESET_STATE = (CLEAR_ON_RESET != 0) ? INIT_CLEAR : READY;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    init_state_e           state, state_next;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  clr_we;
    logic                  a_in_range, b_in_range;
    logic                  a_rd, a_wr, b_rd;
    logic [DATA_WIDTH-1:0] a_word, a_merged, b_word;

    always_ff @(posedge clock) begin
        if (rst) begin
            state    <= RESET_STATE;
            clr_addr <= '0;
        end else begin
            state <= state_next;
            if (clr_we) clr_addr <= clr_addr + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        init_busy  = 1'b0;
        clr_we     = 1'b0;
        if (!rst && state == INIT_CLEAR) begin
            init_busy = 1'b1;
            clr_we    = 1'b1;
            if (clr_addr == LAST_ADDR) state_next = READY;
        end
    end

    assign a_in_range = {1'b0, a_addr} < DEPTH_EXT;
    assign b_in_range = {1'b0, b_addr} < DEPTH_EXT;

    assign a_rd = a_req & ~a_we & ~rst & ~init_busy;
    assign a_wr = a_req & a_we & ~rst & ~init_busy & a_in_range;
    assign b_rd = b_req & ~rst & ~init_busy;

    // Out-of-range reads return zero; a_merged is the word as it will look after A's write.
    always_comb begin
        a_word   = a_in_range ? mem[a_addr] : '0;
        a_merged = a_word;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (a_be[i]) a_merged[i*8 +: 8] = a_wdata[i*8 +: 8];
        end
        b_word = b_in_range ? mem[b_addr] : '0;
        if (WRITE_MODE == WRITE_FIRST && a_wr && a_addr == b_addr) b_word = a_merged;
    end

    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (a_wr) begin
            mem[a_addr] <= a_merged;
        end
    end

    abd_rd_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_a_pipe (
        .clock    (clock),
        .rst      (rst),
        .in_valid (a_rd),
        .in_data  (a_word),
        .out_valid(a_rvalid),
        .out_data (a_rdata)
    );

    abd_rd_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_b_pipe (
        .clock    (clock),
        .rst      (rst),
        .in_valid (b_rd),
        .in_data  (b_word),
        .out_valid(b_rvalid),
        .out_data (b_rdata)
    );

endmodule

// File: tb/tb_abd_dpram.sv
// Bench for abd_dpram: two instances (16 words/latency 1/read-first, 12 words/latency 2/write-first)
// driven with shared stimulus and compared against a cycle-scheduled behavioural model.
module tb_abd_dpram;
    import abd_mem_pkg::*;

    logic        clock = 1'b0;
    logic        rst, a_req, a_we, b_req;
    logic [3:0]  a_be, a_addr, b_addr;
    logic [31:0] a_wdata;

    logic        busy0, a_rvalid0, b_rvalid0, busy1, a_rvalid1, b_rvalid1;
    logic [31:0] a_rdata0, b_rdata0, a_rdata1, b_rdata1;
    logic [66:0] act0, act1;

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    logic [31:0] mem_m [2][16];
    int          init_left [2];
    logic        sv_a [2][4];
    logic        sv_b [2][4];
    logic [31:0] sd_a [2][4];
    logic [31:0] sd_b [2][4];
    logic        ev_a [2];
    logic        ev_b [2];
    logic [31:0] ed_a [2];
    logic [31:0] ed_b [2];
    int          cyc = 0;

    always #5 clock = ~clock;

    assign act0 = {busy0, a_rvalid0, a_rdata0, b_rvalid0, b_rdata0};
    assign act1 = {busy1, a_rvalid1, a_rdata1, b_rvalid1, b_rdata1};

    abd_dpram #(
        .DATA_WIDTH(32), .DEPTH(16), .READ_LATENCY(1),
        .WRITE_MODE(abd_mem_pkg::READ_FIRST), .CLEAR_ON_RESET(1)
    ) u0 (
        .clock(clock), .rst(rst), .init_busy(busy0),
        .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata0), .a_rvalid(a_rvalid0),
        .b_req(b_req), .b_addr(b_addr), .b_rdata(b_rdata0), .b_rvalid(b_rvalid0)
    );

    abd_dpram #(
        .DATA_WIDTH(32), .DEPTH(12), .READ_LATENCY(2),
        .WRITE_MODE(abd_mem_pkg::WRITE_FIRST), .CLEAR_ON_RESET(1)
    ) u1 (
        .clock(clock), .rst(rst), .init_busy(busy1),
        .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
        .b_req(b_req), .b_addr(b_addr), .b_rdata(b_rdata1), .b_rvalid(b_rvalid1)
    );

    function automatic int dep(input int k);
        return (k == 0) ? 16 : 12;
    endfunction

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = be[i] ? wd[i*8 +: 8] : old[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [66:0] exp_vec(input int k);
        if (rst) return '0;
        return {init_left[k] > 0, ev_a[k], ed_a[k], ev_b[k], ed_b[k]};
    endfunction

    // One clock of the reference: requests land in a slot keyed by the cycle their data is due.
    task automatic model_step();
        logic [31:0] w;
        logic        wr;
        int          slot;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                init_left[k] = dep(k);
                for (int s = 0; s < 4; s++) begin
                    sv_a[k][s] = 1'b0;
                    sv_b[k][s] = 1'b0;
                end
                ed_a[k] = '0;
                ed_b[k] = '0;
            end else if (init_left[k] > 0) begin
                mem_m[k][dep(k) - init_left[k]] = '0;
                init_left[k]--;
            end else begin
                wr = a_req && a_we && (int'(a_addr) < dep(k));
                if (b_req) begin
                    w = (int'(b_addr) < dep(k)) ? mem_m[k][b_addr] : '0;
                    if (k == 1 && wr && a_addr == b_addr) w = merge(w, a_wdata, a_be);
                    slot = (cyc + lat(k)) % 4;
                    sv_b[k][slot] = 1'b1;
                    sd_b[k][slot] = w;
                end
                if (a_req && !a_we) begin
                    slot = (cyc + lat(k)) % 4;
                    sv_a[k][slot] = 1'b1;
                    sd_a[k][slot] = (int'(a_addr) < dep(k)) ? mem_m[k][a_addr] : '0;
                end
                if (wr) mem_m[k][a_addr] = merge(mem_m[k][a_addr], a_wdata, a_be);
            end
        end
        cyc++;
        slot = cyc % 4;
        for (int k = 0; k < 2; k++) begin
            ev_a[k] = sv_a[k][slot];
            if (ev_a[k]) ed_a[k] = sd_a[k][slot];
            sv_a[k][slot] = 1'b0;
            ev_b[k] = sv_b[k][slot];
            if (ev_b[k]) ed_b[k] = sd_b[k][slot];
            sv_b[k][slot] = 1'b0;
        end
    endtask

    task automatic set_in(input logic [31:0] r, input logic [31:0] ar, input logic [31:0] awe,
                          input logic [31:0] abe, input logic [31:0] aaddr, input logic [31:0] awd,
                          input logic [31:0] br, input logic [31:0] baddr);
        rst     = r[0];
        a_req   = ar[0];
        a_we    = awe[0];
        a_be    = abe[3:0];
        a_addr  = aaddr[3:0];
        a_wdata = awd;
        b_req   = br[0];
        b_addr  = baddr[3:0];
    endtask

    task automatic advance();
        @(posedge clock);
        model_step();
        @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        int cnt0 = 0;
        int cnt1 = 0;
        for (int i = 0; i < 2; i++) begin
            set_in(1, 0, 0, 0, 0, 0, 0, 0);
            #1;
            n_checks++;
            if ({act0, act1} !== '0) $display("FAIL reset_outputs got=%h exp=0", {act0, act1});
            else n_pass++;
            advance();
        end
        for (int i = 0; i < 16; i++) begin
            set_in(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom, $urandom,
                   $urandom_range(0, 1), $urandom);
            #1;
            if (busy0) cnt0++;
            if (busy1) cnt1++;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ((k == 0 ? act0 : act1) !== exp_vec(k))
                    $display("FAIL init_model u%0d cyc=%0d got=%h exp=%h", k, cyc, (k == 0 ? act0 : act1), exp_vec(k));
                else n_pass++;
            end
            advance();
        end
        n_checks++;
        if (cnt0 != 16) $display("FAIL init_busy_len_u0 got=%0d exp=16", cnt0);
        else n_pass++;
        n_checks++;
        if (cnt1 != 12) $display("FAIL init_busy_len_u1 got=%0d exp=12", cnt1);
        else n_pass++;
        for (int j = 0; j < 3; j++) begin
            if (j == 0) set_in(0, 0, 0, 0, 0, 0, 1, 5);
            else set_in(0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            if (j == 0) begin
                n_checks++;
                if (busy0 !== 1'b0) $display("FAIL first_legal_busy got=%b exp=0", busy0);
                else n_pass++;
            end
            if (j == 1) begin
                n_checks++;
                if ({b_rvalid0, b_rdata0} !== {1'b1, 32'h0})
                    $display("FAIL first_read_addr5 got=%b/%h exp=1/00000000", b_rvalid0, b_rdata0);
                else n_pass++;
            end
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ((k == 0 ? act0 : act1) !== exp_vec(k))
                    $display("FAIL first_read_model u%0d cyc=%0d got=%h exp=%h", k, cyc, (k == 0 ? act0 : act1), exp_vec(k));
                else n_pass++;
            end
            advance();
        end
    endtask

    task automatic test_byte_enable();
        for (int j = 0; j < 5; j++) begin
            case (j)
                0:       set_in(0, 1, 1, 'hF, 3, 'hDEADBEEF, 0, 0);
                1:       set_in(0, 1, 1, 'h1, 3, 'h000000AA, 0, 0);
                2:       set_in(0, 0, 0, 0, 0, 0, 1, 3);
                default: set_in(0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            #1;
            if (j == 3) begin
                n_checks++;
                if ({b_rvalid0, b_rdata0} !== {1'b1, 32'hDEADBEAA})
                    $display("FAIL byte_en_u0 got=%b/%h exp=1/deadbeaa", b_rvalid0, b_rdata0);
                else n_pass++;
            end
            if (j == 4) begin
                n_checks++;
                if ({b_rvalid1, b_rdata1} !== {1'b1, 32'hDEADBEAA})
                    $display("FAIL byte_en_u1 got=%b/%h exp=1/deadbeaa", b_rvalid1, b_rdata1);
                else n_pass++;
            end
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ((k == 0 ? act0 : act1) !== exp_vec(k))
                    $display("FAIL byte_en_model u%0d cyc=%0d got=%h exp=%h", k, cyc, (k == 0 ? act0 : act1), exp_vec(k));
                else n_pass++;
            end
            advance();
        end
    endtask

    task automatic test_collision();
        for (int j = 0; j < 7; j++) begin
            case (j)
                0:       set_in(0, 1, 1, 'hF, 7, 'h11111111, 0, 0);
                1:       set_in(0, 1, 1, 'hF, 7, 'h22222222, 1, 7);
                4:       set_in(0, 0, 0, 0, 0, 0, 1, 7);
                default: set_in(0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            #1;
            if (j == 2) begin
                n_checks++;
                if ({b_rvalid0, b_rdata0} !== {1'b1, 32'h11111111})
                    $display("FAIL collision_read_first got=%b/%h exp=1/11111111", b_rvalid0, b_rdata0);
                else n_pass++;
            end
            if (j == 3) begin
                n_checks++;
                if ({b_rvalid0, b_rdata0} !== {1'b0, 32'h11111111})
                    $display("FAIL rdata_hold got=%b/%h exp=0/11111111", b_rvalid0, b_rdata0);
                else n_pass++;
                n_checks++;
                if ({b_rvalid1, b_rdata1} !== {1'b1, 32'h22222222})
                    $display("FAIL collision_write_first got=%b/%h exp=1/22222222", b_rvalid1, b_rdata1);
                else n_pass++;
            end
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ((k == 0 ? act0 : act1) !== exp_vec(k))
                    $display("FAIL collision_model u%0d cyc=%0d got=%h exp=%h", k, cyc, (k == 0 ? act0 : act1), exp_vec(k));
                else n_pass++;
            end
            advance();
        end
    endtask

    task automatic test_latency2();
        logic [31:0] w;
        for (int j = 0; j < 8; j++) begin
            if (j < 3) set_in(0, 1, 1, 'hF, j, 'hA0 + j, 0, 0);
            else if (j < 6) set_in(0, 0, 0, 0, 0, 0, 1, j - 3);
            else set_in(0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            if (j >= 3) begin
                w = 32'(32'hA0 + j - 5);
                n_checks++;
                if (b_rvalid1 !== (j >= 5) || (j >= 5 && b_rdata1 !== w))
                    $display("FAIL lat2_burst step=%0d got=%b/%h exp=%b/%h", j, b_rvalid1, b_rdata1, (j >= 5), w);
                else n_pass++;
            end
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ((k == 0 ? act0 : act1) !== exp_vec(k))
                    $display("FAIL lat2_model u%0d cyc=%0d got=%h exp=%h", k, cyc, (k == 0 ? act0 : act1), exp_vec(k));
                else n_pass++;
            end
            advance();
        end
    endtask

    task automatic test_rst_mid();
        for (int j = 0; j < 19; j++) begin
            if (j == 0) set_in(0, 1, 0, 0, 2, 0, 0, 0);
            else if (j == 1) set_in(1, 0, 0, 0, 0, 0, 0, 0);
            else set_in(0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            if (j == 1) begin
                n_checks++;
                if ({a_rvalid0, a_rdata0, a_rvalid1, a_rdata1} !== '0)
                    $display("FAIL rst_mid_outputs got=%b/%h %b/%h exp=0", a_rvalid0, a_rdata0, a_rvalid1, a_rdata1);
                else n_pass++;
            end
            if (j == 2) begin
                n_checks++;
                if ({busy0, busy1, a_rvalid1} !== 3'b110)
                    $display("FAIL rst_mid_restart got=%b%b%b exp=110", busy0, busy1, a_rvalid1);
                else n_pass++;
            end
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ((k == 0 ? act0 : act1) !== exp_vec(k))
                    $display("FAIL rst_mid_model u%0d cyc=%0d got=%h exp=%h", k, cyc, (k == 0 ? act0 : act1), exp_vec(k));
                else n_pass++;
            end
            advance();
        end
    endtask

    task automatic test_out_of_range();
        for (int j = 0; j < 16; j++) begin
            if (j == 0) set_in(0, 1, 1, 'hF, 13, 'hFFFFFFFF, 0, 0);
            else if (j == 1) set_in(0, 1, 0, 0, 13, 0, 0, 0);
            else if (j < 14) set_in(0, 0, 0, 0, 0, 0, 1, j - 2);
            else set_in(0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            if (j == 2) begin
                n_checks++;
                if ({a_rvalid0, a_rdata0} !== {1'b1, 32'hFFFFFFFF})
                    $display("FAIL in_range_13_u0 got=%b/%h exp=1/ffffffff", a_rvalid0, a_rdata0);
                else n_pass++;
            end
            if (j == 3) begin
                n_checks++;
                if ({a_rvalid1, a_rdata1} !== {1'b1, 32'h0})
                    $display("FAIL out_of_range_read got=%b/%h exp=1/00000000", a_rvalid1, a_rdata1);
                else n_pass++;
            end
            if (j >= 4) begin
                n_checks++;
                if ({b_rvalid1, b_rdata1} !== {1'b1, 32'h0})
                    $display("FAIL oor_untouched addr=%0d got=%b/%h exp=1/00000000", j - 4, b_rvalid1, b_rdata1);
                else n_pass++;
            end
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ((k == 0 ? act0 : act1) !== exp_vec(k))
                    $display("FAIL oor_model u%0d cyc=%0d got=%h exp=%h", k, cyc, (k == 0 ? act0 : act1), exp_vec(k));
                else n_pass++;
            end
            advance();
        end
    endtask

    task automatic test_random();
        int aa;
        for (int i = 0; i < 400; i++) begin
            aa = $urandom_range(0, 15);
            set_in(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), $urandom_range(0, 1),
                   $urandom, aa, $urandom, $urandom_range(0, 1),
                   ($urandom_range(0, 1) == 1) ? aa : $urandom_range(0, 15));
            #1;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ((k == 0 ? act0 : act1) !== exp_vec(k))
                    $display("FAIL random_model u%0d cyc=%0d got=%h exp=%h", k, cyc, (k == 0 ? act0 : act1), exp_vec(k));
                else n_pass++;
            end
            advance();
        end
    endtask

    initial begin
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        advance();
        test_reset();
        test_byte_enable();
        test_collision();
        test_latency2();
        test_rst_mid();
        test_out_of_range();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/abd_dpram.md
ABD_DPRAM -- requirements
Module: abd_dpram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 1024, number of words (need not be a power of two).
REQ-003 SHALL have parameter READ_LATENCY, default 1, cycles from request to rdata (legal values 1 or 2).
REQ-004 SHALL have parameter WRITE_MODE, default READ_FIRST, same-address collision policy (READ_FIRST or WRITE_FIRST).
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1, zero the whole array after reset when 1.
REQ-006 SHALL derive localparam ADDR_WIDTH = $clog2(DEPTH), minimum 1.
REQ-007 SHALL have ports, in this order:
- clock  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset; synchronous, active-high
- init_busy  out  1  array clear in progress; all requests ignored
- a_req  in  1  port A access request
- a_we  in  1  port A write when 1, read when 0
- a_be  in  DATA_WIDTH/8  port A byte enables for writes
- a_addr  in  ADDR_WIDTH  port A word address
- a_wdata  in  DATA_WIDTH  port A write data
- a_rdata  out  DATA_WIDTH  port A read data
- a_rvalid  out  1  a_rdata valid this cycle
- b_req  in  1  port B read request (read-only fetch port)
- b_addr  in  ADDR_WIDTH  port B word address
- b_rdata  out  DATA_WIDTH  port B read data
- b_rvalid  out  1  b_rdata valid this cycle

Function
REQ-008 SHALL accept a request on a port in any cycle where the port's req=1, rst=0 and init_busy=0; no backpressure.
REQ-009 SHALL present read data for a request accepted in cycle N with rvalid=1 in cycle N+READ_LATENCY, exactly one cycle wide per request; back-to-back reads SHALL give back-to-back data.
REQ-010 SHALL hold rdata at its last valid value while rvalid=0.
REQ-011 SHALL write, on an accepted port-A write, only the bytes whose a_be bit is 1; a write SHALL NOT produce a_rvalid.
REQ-012 SHALL, on a port-A write and a port-B read of the same address in the same cycle, return the pre-write word on B under READ_FIRST and the merged post-write word under WRITE_FIRST.
REQ-013 SHALL, for an address >= DEPTH, drop writes and return all-zero data with normal rvalid timing on reads.
REQ-014 SHALL implement the init state machine with states INIT_CLEAR and READY:
- INIT_CLEAR: a counter writes zero to address 0..DEPTH-1, one word per cycle, with init_busy=1
- INIT_CLEAR to READY after address DEPTH-1 is written
- READY to INIT_CLEAR only via rst
REQ-015 SHALL, with CLEAR_ON_RESET=1, hold init_busy=1 for exactly DEPTH cycles after the first cycle with rst=0; the first request SHALL be accepted in cycle DEPTH after rst falls.
REQ-016 SHALL, with CLEAR_ON_RESET=0, reset straight into READY, never assert init_busy, and leave array contents unchanged by reset.
REQ-017 SHALL ignore requests during INIT_CLEAR; they SHALL produce no rvalid and no write.

Reset
REQ-018 SHALL, while rst=1, drive init_busy=0, a_rvalid=0, b_rvalid=0, a_rdata=0 and b_rdata=0, and clear the read pipeline and init counter.
REQ-019 SHALL, when rst is asserted mid-operation, discard in-flight reads (no rvalid afterwards) and, if CLEAR_ON_RESET=1, restart the clear from address 0.

Structure
REQ-020 SHALL place the WRITE_MODE enum (READ_FIRST, WRITE_FIRST) and the init state enum (INIT_CLEAR, READY) in shared package abd_mem_pkg.
REQ-021 SHALL use one sub-module, abd_rd_pipe, parametrised by DATA_WIDTH and READ_LATENCY, to carry data and valid through the output stage; it is instantiated once per port.
REQ-022 SHALL use only flip-flop state updated through the team's standard flop macros; no latches.

Verification
REQ-023 SHALL cover: CLEAR_ON_RESET=1, DEPTH=16, rst held 2 cycles, then B reads address 5 at the first legal cycle -> init_busy high for exactly 16 cycles; b_rdata=0 and b_rvalid=1 READ_LATENCY cycles after the read.
REQ-024 SHALL cover: A writes 0xDEADBEEF to address 3 with a_be=4'b1111, then writes 0x000000AA with a_be=4'b0001; B reads address 3 -> 0xDEADBEAA.
REQ-025 SHALL cover: address 7 holds 0x11111111; in one cycle A writes 0x22222222 to address 7 and B reads address 7 -> b_rdata=0x11111111 under READ_FIRST, 0x22222222 under WRITE_FIRST.
REQ-026 SHALL cover: READ_LATENCY=2, B reads addresses 0,1,2 on consecutive cycles -> b_rvalid high for 3 consecutive cycles starting 2 cycles after the first request, with data in order.
REQ-027 SHALL cover: rst asserted the cycle after an A read is accepted -> no a_rvalid; a_rdata=0; init restarts, with init_busy=1 the cycle after rst falls.
REQ-028 SHALL cover: DEPTH=12, A writes 0xFFFFFFFF to address 13, then reads address 13 -> a_rdata=0 with a_rvalid=1; addresses 0..11 unchanged.
